// File: rtl/ascon_aead128_pkg.sv
// rtl/ascon_aead128_pkg.sv - shared Ascon types, round-constant table and permutation FSM encoding
//   Provides: ascon_state_t (320-bit, x0 in [319:256] .. x4 in [63:0]), round_t (4-bit round index),
//   ROUNDS_MAX, CONST_ADD[0:11], round_const() lookup and perm_fsm_t {IDLE, RUN, DONE}.
package ascon_aead128_pkg;

  typedef logic [319:0] ascon_state_t;
  typedef logic [3:0]   round_t;

  localparam int ROUNDS_MAX = 12;

  localparam logic [7:0] CONST_ADD [0:11] = '{
    8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
    8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perm_fsm_t;

  // Indices past the table only occur on chain stages evaluated outside RUN;
  // they return 0 so the unused combinational path stays well defined.
  function automatic logic [7:0] round_const(input round_t idx);
    if (idx < 4'(ROUNDS_MAX)) begin
      return CONST_ADD[idx];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/perm_round.sv
// rtl/perm_round.sv - one combinational Ascon round: constant addition, substitution, linear diffusion
//   rnd_i   : round index 0..11 selecting the constant
//   state_i : state before the round
//   state_o : state after the round
module perm_round (
  input  logic [3:0]   rnd_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o
);
  import ascon_aead128_pkg::*;

  function automatic logic [63:0] ror64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  // Constant addition touches word x2 only.
  function automatic logic [319:0] pc(input logic [319:0] s, input round_t r);
    logic [319:0] o;
    o = s;
    o[135:128] = s[135:128] ^ round_const(r);
    return o;
  endfunction

  // Bit-sliced 5-bit S-box applied to all 64 columns at once.
  function automatic logic [319:0] ps(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    {x0, x1, x2, x3, x4} = s;
    x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
    x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
    return {x0, x1, x2, x3, x4};
  endfunction

  function automatic logic [319:0] pl(input logic [319:0] s);
    logic [63:0] x0, x1, x2, x3, x4;
    {x0, x1, x2, x3, x4} = s;
    x0 = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
    x1 = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
    x2 = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
    x3 = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
    x4 = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
    return {x0, x1, x2, x3, x4};
  endfunction

  assign state_o = pl(ps(pc(state_i, rnd_i)));

endmodule

// File: rtl/perm_engine.sv
// rtl/perm_engine.sv - iterative Ascon p^a with unroll factor, per-request round count and handshakes
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : request handshake; in_rounds (1..12) and in_state sampled on accept
//   out_valid/out_ready   : result handshake; out_state is the registered state
//   busy                  : high while rounds are running
//   err                   : one-cycle pulse after an illegal request was rejected
module perm_engine #(
  parameter int UNROLL     = 1,
  parameter int ROUNDS_MAX = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_rounds,
  input  logic [319:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [319:0] out_state,
  output logic         busy,
  output logic         err
);
  import ascon_aead128_pkg::*;

  if (!(UNROLL == 1 || UNROLL == 2 || UNROLL == 4)) begin : g_bad_unroll
    $error("perm_engine: UNROLL must be 1, 2 or 4");
  end
  if (ROUNDS_MAX != ascon_aead128_pkg::ROUNDS_MAX) begin : g_bad_rounds
    $error("perm_engine: ROUNDS_MAX must be 12");
  end

  localparam logic [3:0] RMAX  = 4'(ROUNDS_MAX);
  localparam logic [3:0] USTEP = 4'(UNROLL);
  localparam logic [3:0] UMASK = 4'(UNROLL - 1);

  perm_fsm_t    fsm_q, fsm_d;
  logic [3:0]   rc_q, rc_d;
  logic [319:0] state_q, state_d;
  logic         err_q, err_d;

  logic         accept;
  logic         legal;
  logic [319:0] chain [UNROLL+1];

  assign chain[0] = state_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    perm_round u_round (
      .rnd_i   (rc_q + 4'(k)),
      .state_i (chain[k]),
      .state_o (chain[k+1])
    );
  end

  // in_ready is forced low while reset is held so nothing can be accepted then.
  assign in_ready  = rst_n & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
  assign accept    = in_valid & in_ready;
  assign legal     = (in_rounds != 4'd0) && (in_rounds <= RMAX) && ((in_rounds & UMASK) == 4'd0);

  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q == RUN);
  assign err       = err_q;
  assign out_state = state_q;

  always_comb begin
    fsm_d   = fsm_q;
    rc_d    = rc_q;
    state_d = state_q;
    err_d   = 1'b0;
    case (fsm_q)
      RUN: begin
        state_d = chain[UNROLL];
        rc_d    = rc_q + USTEP;
        if (rc_q + USTEP == RMAX) begin
          fsm_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
    // Accept overrides the IDLE/DONE decisions above; in DONE this gives the
    // back-to-back start in the same edge the previous result drains.
    if (accept) begin
      if (legal) begin
        state_d = in_state;
        rc_d    = RMAX - in_rounds;
        fsm_d   = RUN;
      end else begin
        err_d   = 1'b1;
        fsm_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= IDLE;
      rc_q    <= 4'd0;
      state_q <= '0;
      err_q   <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      rc_q    <= rc_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // The round index never reaches past the table while rounds are applied.
  a_rc_range: assert property (@(posedge clk) disable iff (!rst_n)
    (fsm_q == RUN) |-> (5'(rc_q) + 5'(UNROLL) <= 5'(ROUNDS_MAX)));

endmodule

// File: tb/tb_perm_engine.sv
// tb/tb_perm_engine.sv - self-checking bench for perm_engine at UNROLL 1, 2 and 4
module tb_perm_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [3:0]   in_rounds [3];
  logic [319:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [319:0] out_state [3];
  logic         busy      [3];
  logic         err       [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    perm_engine #(.UNROLL(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_rounds (in_rounds[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .busy      (busy[g]),
      .err       (err[g])
    );
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Ascon S-box as a 32-entry table, index = {x0,x1,x2,x3,x4} bit of one column.
  logic [4:0] sbox_t [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
  };

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  function automatic logic [319:0] model_perm(input logic [319:0] s, input int rounds);
    logic [63:0] x [5];
    logic [63:0] y [5];
    logic [4:0]  col;
    for (int i = 0; i < 5; i++) x[i] = s[319 - 64*i -: 64];
    for (int r = 12 - rounds; r < 12; r++) begin
      x[2] ^= 64'(((15 - r) << 4) | r);
      for (int b = 0; b < 64; b++) begin
        col = sbox_t[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        for (int i = 0; i < 5; i++) y[i][b] = col[4 - i];
      end
      x[0] = y[0] ^ rotr(y[0], 19) ^ rotr(y[0], 28);
      x[1] = y[1] ^ rotr(y[1], 61) ^ rotr(y[1], 39);
      x[2] = y[2] ^ rotr(y[2], 1)  ^ rotr(y[2], 6);
      x[3] = y[3] ^ rotr(y[3], 10) ^ rotr(y[3], 17);
      x[4] = y[4] ^ rotr(y[4], 7)  ^ rotr(y[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] rand_state();
    logic [319:0] s;
    for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
    return s;
  endfunction

  task automatic start(input int u, input int rounds, input logic [319:0] st);
    in_valid[u]  = 1'b1;
    in_rounds[u] = 4'(rounds);
    in_state[u]  = st;
    #1;
    check("start_in_ready", in_ready[u], 1);
    @(negedge clk);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
  endtask

  // Called at the first falling edge after the accepting rising edge.
  task automatic wait_result(input int u, input int exp_lat, input logic [319:0] exp_st, input string tag);
    int n = 1;
    int busy_cnt = 0;
    while (!out_valid[u] && n <= 100) begin
      if (busy[u]) busy_cnt++;
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"},   out_valid[u], 1);
    check({tag, "_latency"}, n - 1, exp_lat);
    check({tag, "_busy"},    busy_cnt, exp_lat);
    check({tag, "_state"},   out_state[u], exp_st);
  endtask

  task automatic drain(input int u);
    out_ready[u] = 1'b1;
    @(negedge clk);
    check("drain_valid", out_valid[u], 0);
    out_ready[u] = 1'b0;
  endtask

  task automatic illegal(input int u, input int rounds, input logic [319:0] held);
    in_valid[u]  = 1'b1;
    in_rounds[u] = 4'(rounds);
    in_state[u]  = rand_state();
    out_ready[u] = 1'b1;
    #1;
    check("ill_in_ready", in_ready[u], 1);
    @(negedge clk);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
    check("ill_err",      err[u], 1);
    check("ill_no_valid", out_valid[u], 0);
    check("ill_not_busy", busy[u], 0);
    check("ill_ready",    in_ready[u], 1);
    check("ill_state",    out_state[u], held);
    @(negedge clk);
    check("ill_err_pulse", err[u], 0);
  endtask

  task automatic soak(input int u, input int nreq);
    logic [319:0] q [$];
    int  issued = 0;
    int  n = 0;
    int  r;
    int  step;
    bit  pend = 0;
    bit  err_exp = 0;
    bit  legal_cur = 0;
    step = 1 << u;
    while ((issued < nreq || pend || q.size() != 0) && n < 30000) begin
      @(negedge clk);
      n++;
      check("soak_err", err[u], err_exp);
      err_exp = 0;
      if (!pend) in_valid[u] = 1'b0;
      out_ready[u] = ($urandom_range(0, 3) != 0);
      if (!pend && issued < nreq && $urandom_range(0, 2) != 0) begin
        if ($urandom_range(0, 4) != 0) r = $urandom_range(1, 12 / step) * step;
        else r = $urandom_range(0, 15);
        legal_cur    = (r >= 1) && (r <= 12) && (r % step == 0);
        in_rounds[u] = 4'(r);
        in_state[u]  = rand_state();
        in_valid[u]  = 1'b1;
        pend = 1;
        issued++;
      end
      #1;
      if (out_valid[u] && out_ready[u]) begin
        if (q.size() == 0) check("soak_extra_out", 1, 0);
        else check("soak_data", out_state[u], q.pop_front());
      end
      if (pend && in_ready[u]) begin
        if (legal_cur) q.push_back(model_perm(in_state[u], int'(in_rounds[u])));
        else err_exp = 1;
        pend = 0;
      end
    end
    @(negedge clk);
    check("soak_err_last", err[u], err_exp);
    check("soak_timeout", n < 30000, 1);
    check("soak_leftover", q.size(), 0);
    in_valid[u]  = 1'b0;
    out_ready[u] = 1'b0;
  endtask

  logic [319:0] s, exp_st;

  initial begin
    rst_n = 1'b0;
    for (int u = 0; u < 3; u++) begin
      in_valid[u] = 1'b0; in_rounds[u] = '0; in_state[u] = '0; out_ready[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      check("rst_in_ready",  in_ready[u], 0);
      check("rst_out_valid", out_valid[u], 0);
      check("rst_busy",      busy[u], 0);
      check("rst_err",       err[u], 0);
      check("rst_out_state", out_state[u], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: p12 on zero state, UNROLL=1
    start(0, 12, '0);
    wait_result(0, 12, model_perm('0, 12), "p12_zero");
    drain(0);

    // Scenario 2: p8 at UNROLL 2 and 4
    s = rand_state();
    start(1, 8, s);
    wait_result(1, 4, model_perm(s, 8), "p8_u2");
    drain(1);
    s = rand_state();
    start(2, 8, s);
    wait_result(2, 2, model_perm(s, 8), "p8_u4");
    exp_st = model_perm(s, 8);
    drain(2);

    // Scenario 3: illegal requests
    illegal(2, 0, exp_st);
    illegal(2, 13, exp_st);
    illegal(2, 6, exp_st);
    s = rand_state();
    start(0, 12, s);
    exp_st = model_perm(s, 12);
    wait_result(0, 12, exp_st, "p12_pre_ill");
    illegal(0, 13, exp_st);

    // Scenario 4: back-pressure then back-to-back
    s = rand_state();
    start(0, 6, s);
    exp_st = model_perm(s, 6);
    wait_result(0, 6, exp_st, "p6_bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", out_valid[0], 1);
      check("bp_state_held", out_state[0], exp_st);
    end
    out_ready[0] = 1'b1;
    s = rand_state();
    start(0, 12, s);
    check("b2b_no_bubble", busy[0], 1);
    check("b2b_valid_low", out_valid[0], 0);
    wait_result(0, 12, model_perm(s, 12), "p12_b2b");
    drain(0);

    // Scenario 5: reset during RUN cycle 5
    start(0, 12, rand_state());
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    out_valid[0], 0);
    check("mid_rst_busy",     busy[0], 0);
    check("mid_rst_in_ready", in_ready[0], 0);
    check("mid_rst_state",    out_state[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    s = rand_state();
    start(0, 12, s);
    wait_result(0, 12, model_perm(s, 12), "p12_after_rst");
    drain(0);

    // Scenario 6: random soak on every unroll factor
    for (int u = 0; u < 3; u++) soak(u, 400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
